// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit
// ---------------------------------------------------------------------------
// RV32I execute-stage core: control decoder, branch comparator and 32-bit ALU.
// It takes the EX-stage instruction and operands and produces the control
// fields the rest of the pipe needs (operand-mux selects, memory controls,
// write-back select and the fetch redirect). The whole datapath is
// combinational. The only state is the sticky illegal-instruction flag.
//
// Optional build feature (macro EXEC_BYPASS_EN):
//   defined   - the comparator operands come through the MX/WX bypass muxes
//               selected by byp_sel_rs1 / byp_sel_rs2.
//   undefined - the comparator uses rs1_data / rs2_data directly and the
//               bypass selects are ignored.
//   The ALU path does not depend on this macro.
//
// Ports
//   clock, reset          rising-edge clock; synchronous active-high reset
//   inst                  EX instruction (32'h0 is a pipeline bubble)
//   rs1_data, rs2_data    EX register operands
//   mx_data, wx_data      MEM / WB bypass values for the comparator
//   byp_sel_rs1/rs2       0 reg, 1 MX, 2 WX, 3 reg
//   inp1, inp2            ALU operands from the operand mux
//   alu_out               ALU result
//   asel, bsel, alu_sel   operand-mux and ALU controls
//   pc_sel, br_taken      fetch redirect and conditional-branch outcome
//   br_eq, br_lt          comparator results
//   wr_en, access_size, unsigned_sel, dmem_rw, wb_sel
//                         register-file / memory / write-back controls
//   illegal               sticky: an unknown opcode has been seen
// ---------------------------------------------------------------------------
module exec_ctrl_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] mx_data,
  input  logic [XLEN-1:0] wx_data,
  input  logic [1:0]      byp_sel_rs1,
  input  logic [1:0]      byp_sel_rs2,
  input  logic [XLEN-1:0] inp1,
  input  logic [XLEN-1:0] inp2,
  output logic [XLEN-1:0] alu_out,
  output logic [1:0]      asel,
  output logic [1:0]      bsel,
  output logic [3:0]      alu_sel,
  output logic            pc_sel,
  output logic            br_taken,
  output logic            br_eq,
  output logic            br_lt,
  output logic            wr_en,
  output logic [1:0]      access_size,
  output logic            unsigned_sel,
  output logic            dmem_rw,
  output logic [1:0]      wb_sel,
  output logic            illegal
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7_b5 = inst[30];

  // funct3 -> ALU op shared by R-type and I-ALU. alt_sub is only honoured
  // for R-type (ADDI has no subtract form, and bit 30 of its immediate is
  // data); alt_sra applies to both.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt_sub,
                                                 input logic       alt_sra);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------
  // Branch comparator
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            br_un;

`ifdef EXEC_BYPASS_EN
  always_comb begin
    case (byp_sel_rs1)
      2'd1:    cmp_a = mx_data;
      2'd2:    cmp_a = wx_data;
      default: cmp_a = rs1_data;
    endcase
    case (byp_sel_rs2)
      2'd1:    cmp_b = mx_data;
      2'd2:    cmp_b = wx_data;
      default: cmp_b = rs2_data;
    endcase
  end
`else
  // Bypass inputs exist on the port list but play no part in this build.
  logic unused_byp;
  assign unused_byp = ^{byp_sel_rs1, byp_sel_rs2, mx_data, wx_data};
  assign cmp_a = rs1_data;
  assign cmp_b = rs2_data;
`endif

  // Only BLTU/BGEU compare unsigned.
  assign br_un = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b11);
  assign br_eq = (cmp_a == cmp_b);
  assign br_lt = br_un ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  logic is_jump;
  logic bad_op;

  always_comb begin
    asel         = 2'd0;
    bsel         = 2'd0;
    alu_sel      = ALU_ADD;
    wr_en        = 1'b0;
    access_size  = 2'd2;
    unsigned_sel = 1'b0;
    dmem_rw      = 1'b0;
    wb_sel       = 2'd1;
    br_taken     = 1'b0;
    is_jump      = 1'b0;
    bad_op       = 1'b0;

    case (opcode)
      OP_R: begin
        wr_en   = 1'b1;
        alu_sel = alu_from_funct3(funct3, funct7_b5, funct7_b5);
      end
      OP_I: begin
        wr_en   = 1'b1;
        bsel    = (funct3[1:0] == 2'b01) ? 2'd2 : 2'd1;
        alu_sel = alu_from_funct3(funct3, 1'b0, funct7_b5);
      end
      OP_LOAD: begin
        bsel         = 2'd1;
        wr_en        = 1'b1;
        wb_sel       = 2'd0;
        access_size  = funct3[1:0];
        unsigned_sel = funct3[2];
      end
      OP_STORE: begin
        bsel        = 2'd1;
        dmem_rw     = 1'b1;
        access_size = funct3[1:0];
      end
      OP_BRANCH: begin
        asel = 2'd1;
        bsel = 2'd1;
        case (funct3)
          3'b000:  br_taken = br_eq;
          3'b001:  br_taken = !br_eq;
          3'b100:  br_taken = br_lt;
          3'b101:  br_taken = !br_lt;
          3'b110:  br_taken = br_lt;
          3'b111:  br_taken = !br_lt;
          default: br_taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        asel    = 2'd1;
        bsel    = 2'd1;
        wr_en   = 1'b1;
        wb_sel  = 2'd2;
        is_jump = 1'b1;
      end
      OP_JALR: begin
        bsel    = 2'd1;
        wr_en   = 1'b1;
        wb_sel  = 2'd2;
        is_jump = 1'b1;
      end
      OP_LUI: begin
        bsel    = 2'd1;
        alu_sel = ALU_PASSB;
        wr_en   = 1'b1;
      end
      OP_AUIPC: begin
        asel  = 2'd1;
        bsel  = 2'd1;
        wr_en = 1'b1;
      end
      OP_SYSTEM: begin
        // No side effects in this stage; defaults only.
      end
      default: begin
        // An all-zero word is a bubble, not an illegal instruction.
        bad_op = (inst != 32'h0);
      end
    endcase
  end

  assign pc_sel = is_jump | br_taken;

  // ---------------------------------------------------------------------
  // Sticky illegal flag (reset wins over a coincident illegal opcode)
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal <= 1'b0;
    end else if (bad_op) begin
      illegal <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  logic [4:0] shamt;
  assign shamt = inp2[4:0];

  always_comb begin
    case (alu_sel)
      ALU_ADD:   alu_out = inp1 + inp2;
      ALU_SUB:   alu_out = inp1 - inp2;
      ALU_SLL:   alu_out = inp1 << shamt;
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (inp1 < inp2)};
      ALU_XOR:   alu_out = inp1 ^ inp2;
      ALU_SRL:   alu_out = inp1 >> shamt;
      ALU_SRA:   alu_out = $unsigned($signed(inp1) >>> shamt);
      ALU_OR:    alu_out = inp1 | inp2;
      ALU_AND:   alu_out = inp1 & inp2;
      ALU_PASSB: alu_out = inp2;
      default:   alu_out = '0;
    endcase
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Testbench for exec_ctrl_unit: decode vector table, directed ALU and
// branch cases, randomized ALU / comparator / ALU-decode checks against a
// reference model, and the sticky illegal-flag sequences.
module tb_exec_ctrl_unit;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = 32'h0;
  logic [31:0] rs1_data = 32'h0, rs2_data = 32'h0;
  logic [31:0] mx_data = 32'h0, wx_data = 32'h0;
  logic [1:0]  byp_sel_rs1 = 2'd0, byp_sel_rs2 = 2'd0;
  logic [31:0] inp1 = 32'h0, inp2 = 32'h0;
  logic [31:0] alu_out;
  logic [1:0]  asel, bsel;
  logic [3:0]  alu_sel;
  logic        pc_sel, br_taken, br_eq, br_lt, wr_en;
  logic [1:0]  access_size;
  logic        unsigned_sel, dmem_rw;
  logic [1:0]  wb_sel;
  logic        illegal;

  always #5 clock = ~clock;

  exec_ctrl_unit dut (
    .clock(clock), .reset(reset), .inst(inst),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mx_data(mx_data), .wx_data(wx_data),
    .byp_sel_rs1(byp_sel_rs1), .byp_sel_rs2(byp_sel_rs2),
    .inp1(inp1), .inp2(inp2), .alu_out(alu_out),
    .asel(asel), .bsel(bsel), .alu_sel(alu_sel),
    .pc_sel(pc_sel), .br_taken(br_taken), .br_eq(br_eq), .br_lt(br_lt),
    .wr_en(wr_en), .access_size(access_size), .unsigned_sel(unsigned_sel),
    .dmem_rw(dmem_rw), .wb_sel(wb_sel), .illegal(illegal)
  );

  // Watchdog: the run is short; anything past this is a hang.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the observed value.
  task automatic check_q(input string name, input logic [31:0] act);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%h required=<queue empty>", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    int unsigned sh;
    sa = int'(a);
    sb = int'(b);
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                       input logic [31:0] mx, input logic [31:0] wx);
`ifdef EXEC_BYPASS_EN
    if (sel == 2'd1) return mx;
    if (sel == 2'd2) return wx;
    return reg_v;
`else
    return reg_v;
`endif
  endfunction

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] inst, rs1, rs2;
    logic [1:0]  asel, bsel;
    logic [3:0]  alu_sel;
    logic        pc_sel, br_taken, br_eq, br_lt, wr_en;
    logic [1:0]  access_size;
    logic        unsigned_sel, dmem_rw;
    logic [1:0]  wb_sel;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [1:0] a, input logic [1:0] b, input logic [3:0] al,
                              input logic pc, input logic bt, input logic eq, input logic lt,
                              input logic wr, input logic [1:0] acc, input logic uns,
                              input logic rw, input logic [1:0] wb);
    vec_t v;
    v.inst = i; v.rs1 = r1; v.rs2 = r2; v.asel = a; v.bsel = b; v.alu_sel = al;
    v.pc_sel = pc; v.br_taken = bt; v.br_eq = eq; v.br_lt = lt; v.wr_en = wr;
    v.access_size = acc; v.unsigned_sel = uns; v.dmem_rw = rw; v.wb_sel = wb;
    return v;
  endfunction

  vec_t vecs[17];

  // ---------------- driver helpers ----------------
  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [1:0] s1, input logic [1:0] s2,
                              input logic [31:0] mx, input logic [31:0] wx);
    @(negedge clock);
    inst = {7'd0, 5'd2, 5'd1, f3, 5'd8, 7'b1100011};
    rs1_data = r1; rs2_data = r2; byp_sel_rs1 = s1; byp_sel_rs2 = s2;
    mx_data = mx; wx_data = wx;
    #1;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    inst = 32'h0;
    force dut.alu_sel = op;
    inp1 = a; inp2 = b;
    #1;
  endtask

  logic [31:0] corners[5];

  initial begin
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'hFFFF_FFFF;

    //                 inst          rs1           rs2       a  b  alu pc bt eq lt wr acc u rw wb
    vecs[0]  = mk(32'h0040A103, 32'h0,        32'h0, 0, 1, 0,  0, 0, 1, 0, 1, 2, 0, 0, 0); // LW
    vecs[1]  = mk(32'h00208023, 32'h0,        32'h0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0, 1, 1); // SB
    vecs[2]  = mk(32'h0080006F, 32'h0,        32'h0, 1, 1, 0,  1, 0, 1, 0, 1, 2, 0, 0, 2); // JAL
    vecs[3]  = mk(32'h00000000, 32'h0,        32'h0, 0, 0, 0,  0, 0, 1, 0, 0, 2, 0, 0, 1); // bubble
    vecs[4]  = mk(32'h0020E463, 32'hFFFFFFFF, 32'h1, 1, 1, 0,  0, 0, 0, 0, 0, 2, 0, 0, 1); // BLTU
    vecs[5]  = mk(32'h0020C463, 32'hFFFFFFFF, 32'h1, 1, 1, 0,  1, 1, 0, 1, 0, 2, 0, 0, 1); // BLT
    vecs[6]  = mk(32'h0020F463, 32'hFFFFFFFF, 32'h1, 1, 1, 0,  1, 1, 0, 0, 0, 2, 0, 0, 1); // BGEU
    vecs[7]  = mk(32'h402081B3, 32'h5,        32'h7, 0, 0, 1,  0, 0, 0, 1, 1, 2, 0, 0, 1); // SUB
    vecs[8]  = mk(32'h4040D193, 32'h0,        32'h0, 0, 2, 7,  0, 0, 1, 0, 1, 2, 0, 0, 1); // SRAI
    vecs[9]  = mk(32'hFFF08193, 32'h0,        32'h0, 0, 1, 0,  0, 0, 1, 0, 1, 2, 0, 0, 1); // ADDI -1
    vecs[10] = mk(32'h123452B7, 32'h0,        32'h0, 0, 1, 10, 0, 0, 1, 0, 1, 2, 0, 0, 1); // LUI
    vecs[11] = mk(32'h00001297, 32'h0,        32'h0, 1, 1, 0,  0, 0, 1, 0, 1, 2, 0, 0, 1); // AUIPC
    vecs[12] = mk(32'h000100E7, 32'h0,        32'h0, 0, 1, 0,  1, 0, 1, 0, 1, 2, 0, 0, 2); // JALR
    vecs[13] = mk(32'h00000073, 32'h0,        32'h0, 0, 0, 0,  0, 0, 1, 0, 0, 2, 0, 0, 1); // ECALL
    vecs[14] = mk(32'h0000D183, 32'h0,        32'h0, 0, 1, 0,  0, 0, 1, 0, 1, 1, 1, 0, 0); // LHU
    vecs[15] = mk(32'h0020B1B3, 32'hFFFFFFFF, 32'h1, 0, 0, 4,  0, 0, 0, 1, 1, 2, 0, 0, 1); // SLTU
    vecs[16] = mk(32'h00208463, 32'h7,        32'h7, 1, 1, 0,  1, 1, 1, 0, 0, 2, 0, 0, 1); // BEQ

    // ---------------- reset ----------------
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_illegal", {31'd0, illegal}, 32'd0);

    // ---------------- decode table ----------------
    foreach (vecs[i]) begin
      @(negedge clock);
      inst = vecs[i].inst; rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
      byp_sel_rs1 = 2'd0; byp_sel_rs2 = 2'd0;
      mx_data = 32'hA5A5_0001; wx_data = 32'h5A5A_0002;
      #1;
      check($sformatf("v%0d_asel", i),   {30'd0, asel},        {30'd0, vecs[i].asel});
      check($sformatf("v%0d_bsel", i),   {30'd0, bsel},        {30'd0, vecs[i].bsel});
      check($sformatf("v%0d_alu_sel", i), {28'd0, alu_sel},    {28'd0, vecs[i].alu_sel});
      check($sformatf("v%0d_pc_sel", i), {31'd0, pc_sel},      {31'd0, vecs[i].pc_sel});
      check($sformatf("v%0d_br_taken", i), {31'd0, br_taken},  {31'd0, vecs[i].br_taken});
      check($sformatf("v%0d_br_eq", i),  {31'd0, br_eq},       {31'd0, vecs[i].br_eq});
      check($sformatf("v%0d_br_lt", i),  {31'd0, br_lt},       {31'd0, vecs[i].br_lt});
      check($sformatf("v%0d_wr_en", i),  {31'd0, wr_en},       {31'd0, vecs[i].wr_en});
      check($sformatf("v%0d_access", i), {30'd0, access_size}, {30'd0, vecs[i].access_size});
      check($sformatf("v%0d_unsigned", i), {31'd0, unsigned_sel}, {31'd0, vecs[i].unsigned_sel});
      check($sformatf("v%0d_dmem_rw", i), {31'd0, dmem_rw},    {31'd0, vecs[i].dmem_rw});
      check($sformatf("v%0d_wb_sel", i), {30'd0, wb_sel},      {30'd0, vecs[i].wb_sel});
    end
    @(posedge clock); #1;
    check("legal_table_illegal", {31'd0, illegal}, 32'd0);

    // ---------------- directed ALU ----------------
    drive_alu(4'd1, 32'd5, 32'd7);
    check("alu_sub_5_7", alu_out, 32'hFFFF_FFFE);
    drive_alu(4'd7, 32'h8000_0000, 32'd4);
    check("alu_sra_neg", alu_out, 32'hF800_0000);
    drive_alu(4'd6, 32'h8000_0000, 32'h0000_0024); // only inp2[4:0] counts
    check("alu_srl_shamt_mask", alu_out, 32'h0800_0000);
    drive_alu(4'd0, 32'hFFFF_FFFF, 32'd1);
    check("alu_add_wrap", alu_out, 32'h0);
    drive_alu(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("alu_unused_code", alu_out, 32'h0);

    // ---------------- randomized ALU ----------------
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      exp_q.push_back(alu_ref(op, a, b));
      drive_alu(op, a, b);
      check_q($sformatf("alu_rand op=%0d a=%h b=%h", op, a, b), alu_out);
    end
    @(negedge clock);
    release dut.alu_sel;

    // ---------------- bypass behaviour of the comparator ----------------
    drive_branch(3'b000, 32'd0, 32'd9, 2'd1, 2'd0, 32'd9, 32'd3);
`ifdef EXEC_BYPASS_EN
    check("byp_beq_eq", {31'd0, br_eq}, 32'd1);
    check("byp_beq_taken", {31'd0, br_taken}, 32'd1);
`else
    check("nobyp_beq_eq", {31'd0, br_eq}, 32'd0);
    check("nobyp_beq_taken", {31'd0, br_taken}, 32'd0);
`endif

    // ---------------- randomized branches ----------------
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  f3;
      logic [31:0] r1, r2, mx, wx, a, b;
      logic [1:0]  s1, s2;
      logic        e_eq, e_lt, e_tk;
      f3 = 3'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      mx = ($urandom_range(0, 2) == 0) ? r2 : $urandom;
      wx = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
      s1 = 2'($urandom_range(0, 3));
      s2 = 2'($urandom_range(0, 3));
      a = pick(s1, r1, mx, wx);
      b = pick(s2, r2, mx, wx);
      e_eq = (a == b);
      e_lt = (f3 >= 3'd6) ? (a < b) : (int'(a) < int'(b));
      case (f3)
        3'd0: e_tk = e_eq;
        3'd1: e_tk = !e_eq;
        3'd4, 3'd6: e_tk = e_lt;
        3'd5, 3'd7: e_tk = !e_lt;
        default: e_tk = 1'b0;
      endcase
      drive_branch(f3, r1, r2, s1, s2, mx, wx);
      check($sformatf("br_eq f3=%0d", f3), {31'd0, br_eq}, {31'd0, e_eq});
      check($sformatf("br_lt f3=%0d", f3), {31'd0, br_lt}, {31'd0, e_lt});
      check($sformatf("br_taken f3=%0d", f3), {31'd0, br_taken}, {31'd0, e_tk});
      check($sformatf("br_pc_sel f3=%0d", f3), {31'd0, pc_sel}, {31'd0, e_tk});
    end

    // ---------------- randomized R / I-ALU decode ----------------
    for (int n = 0; n < 100; n++) begin
      logic [2:0] f3;
      logic       alt, is_r;
      logic [3:0] e_alu;
      logic [1:0] e_bsel;
      logic [3:0] base_op[8];
      base_op[0] = 0; base_op[1] = 2; base_op[2] = 3; base_op[3] = 4;
      base_op[4] = 5; base_op[5] = 6; base_op[6] = 8; base_op[7] = 9;
      f3 = 3'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      is_r = 1'($urandom_range(0, 1));
      e_alu = base_op[f3];
      if (alt && f3 == 3'd5) e_alu = 4'd7;
      if (alt && f3 == 3'd0 && is_r) e_alu = 4'd1;
      e_bsel = is_r ? 2'd0 : ((f3 == 3'd1 || f3 == 3'd5) ? 2'd2 : 2'd1);
      @(negedge clock);
      inst = {1'b0, alt, 5'd0, 5'($urandom), 5'($urandom), f3, 5'($urandom),
              is_r ? 7'b0110011 : 7'b0010011};
      #1;
      check($sformatf("dec_alu r=%0d f3=%0d alt=%0d", is_r, f3, alt), {28'd0, alu_sel}, {28'd0, e_alu});
      check($sformatf("dec_bsel r=%0d f3=%0d", is_r, f3), {30'd0, bsel}, {30'd0, e_bsel});
      check("dec_wr_en", {31'd0, wr_en}, 32'd1);
    end

    // ---------------- illegal opcode: sticky flag ----------------
    @(negedge clock);
    inst = 32'hFFFF_FFFF;
    #1;
    check("illegal_before_edge", {31'd0, illegal}, 32'd0);
    check("illegal_wr_en", {31'd0, wr_en}, 32'd0);
    check("illegal_pc_sel", {31'd0, pc_sel}, 32'd0);
    check("illegal_dmem_rw", {31'd0, dmem_rw}, 32'd0);
    check("illegal_wb_sel", {30'd0, wb_sel}, 32'd1);
    check("illegal_access", {30'd0, access_size}, 32'd2);
    @(posedge clock); #1;
    check("illegal_set", {31'd0, illegal}, 32'd1);
    @(negedge clock);
    inst = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("illegal_held", {31'd0, illegal}, 32'd1);

    // Reset with an illegal opcode on the same edge: reset wins.
    @(negedge clock);
    reset = 1'b1;
    inst = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    check("reset_priority", {31'd0, illegal}, 32'd0);
    @(negedge clock);
    inst = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset_release", {31'd0, illegal}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
